arch_state_unit: RTL

//  Parametrised successor to the multi-cycle CPU's PC/IR/SR registers: one block holding PC, IR, SR and

---
 rtl/arch_state_pkg.sv | 23 ++
 rtl/en_reg.sv | 21 ++
 rtl/arch_state_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/arch_state_pkg.sv
// rtl/arch_state_pkg.sv - shared encodings for the architectural state unit
package arch_state_pkg;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_SEQ  = 2'b01,
    PC_LOAD = 2'b10,
    PC_RET  = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_EXT      = 2'b01,
    EXC_MISALIGN = 2'b10,
    EXC_TIMEOUT  = 2'b11
  } exc_cause_e;

  typedef enum logic [0:0] {
    FS_IDLE = 1'b0,
    FS_REQ  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/en_reg.sv
// rtl/en_reg.sv - enable register with synchronous active-low reset
module en_reg #(
  parameter int unsigned W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_o <= RST_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/arch_state_unit.sv
// rtl/arch_state_unit.sv - PC/IR/SR/EPC/ESR state with exception entry/return
// and a req/ack instruction fetch guarded by a watchdog.
module arch_state_unit
  import arch_state_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = 32'h0040_0000,
  parameter logic [XLEN-1:0] EXC_VEC    = 32'h8000_0180,
  parameter int unsigned     ILEN_BYTES = 4,
  parameter int unsigned     SR_W       = 4,
  parameter int unsigned     TIMEOUT    = 15
) (
  input  logic            clock_i,
  input  logic            rst_i,
  input  logic [1:0]      pc_sel_i,
  input  logic            pc_we_i,
  input  logic [XLEN-1:0] pc_in_i,
  input  logic            exc_req_i,
  input  logic [SR_W-1:0] sr_in_i,
  input  logic [SR_W-1:0] sr_mask_i,
  input  logic            fetch_start_i,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  output logic [XLEN-1:0] pc_out_o,
  output logic [XLEN-1:0] ir_out_o,
  output logic            ir_valid_o,
  output logic            fetch_busy_o,
  output logic [SR_W-1:0] sr_out_o,
  output logic [XLEN-1:0] epc_out_o,
  output logic            exc_taken_o,
  output logic [1:0]      exc_cause_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  pc_sel_e         sel;
  fetch_state_e    state_q, state_d;
  exc_cause_e      cause_q, cause_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d, ir_q, epc_q, addr_q;
  logic [SR_W-1:0] sr_q, sr_d, esr_q;
  logic            ir_valid_q, taken_q;
  logic            in_req, timeout, misaligned, exc, ret, pc_en, fetch_done, fetch_go;

  assign sel = pc_sel_e'(pc_sel_i);

  always_comb begin
    in_req     = (state_q == FS_REQ);
    timeout    = in_req && !imem_ack_i && (cnt_q == CW'(TIMEOUT));
    misaligned = pc_we_i && (sel == PC_LOAD) && ((pc_in_i & XLEN'(ILEN_BYTES - 1)) != '0);
    exc        = timeout || exc_req_i || misaligned;
    ret        = !exc && pc_we_i && (sel == PC_RET);
    pc_en      = exc || (pc_we_i && (sel != PC_HOLD));
    fetch_done = in_req && imem_ack_i && !exc;
    fetch_go   = !in_req && fetch_start_i && !exc;

    if (timeout)        cause_d = EXC_TIMEOUT;
    else if (exc_req_i) cause_d = EXC_EXT;
    else                cause_d = EXC_MISALIGN;

    pc_d = pc_q;
    if (exc) begin
      pc_d = EXC_VEC;
    end else begin
      case (sel)
        PC_SEQ:  pc_d = pc_q + XLEN'(ILEN_BYTES);
        PC_LOAD: pc_d = pc_in_i;
        PC_RET:  pc_d = epc_q;
        default: pc_d = pc_q;
      endcase
    end

    if (exc)      sr_d = '0;
    else if (ret) sr_d = esr_q;
    else          sr_d = (sr_q & ~sr_mask_i) | (sr_in_i & sr_mask_i);

    // Counter holds the number of REQ cycles elapsed, including the current one.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (exc || fetch_done) begin
      state_d = FS_IDLE;
      cnt_d   = '0;
    end else if (in_req) begin
      cnt_d = cnt_q + CW'(1);
    end else if (fetch_go) begin
      state_d = FS_REQ;
      cnt_d   = CW'(1);
    end
  end

  en_reg #(.W(XLEN), .RST_VAL(RESET_VEC)) u_pc (
    .clk_i(clock_i), .rst_ni(rst_i), .en_i(pc_en), .d_i(pc_d), .q_o(pc_q));
  en_reg #(.W(XLEN), .RST_VAL('0)) u_ir (
    .clk_i(clock_i), .rst_ni(rst_i), .en_i(fetch_done), .d_i(imem_rdata_i), .q_o(ir_q));
  en_reg #(.W(XLEN), .RST_VAL('0)) u_epc (
    .clk_i(clock_i), .rst_ni(rst_i), .en_i(exc), .d_i(pc_q), .q_o(epc_q));
  en_reg #(.W(SR_W), .RST_VAL('0)) u_esr (
    .clk_i(clock_i), .rst_ni(rst_i), .en_i(exc), .d_i(sr_q), .q_o(esr_q));

  always_ff @(posedge clock_i) begin
    if (!rst_i) begin
      sr_q       <= '0;
      ir_valid_q <= 1'b0;
      cause_q    <= EXC_NONE;
      taken_q    <= 1'b0;
      state_q    <= FS_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
    end else begin
      sr_q    <= sr_d;
      taken_q <= exc;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (exc)      cause_q <= cause_d;
      if (fetch_go) addr_q  <= pc_q;
      // A fetch only validates IR if its address still matches the PC.
      if (pc_en)           ir_valid_q <= 1'b0;
      else if (fetch_done) ir_valid_q <= (addr_q == pc_q);
    end
  end

  assign imem_req_o   = (state_q == FS_REQ);
  assign fetch_busy_o = (state_q != FS_IDLE);
  assign imem_addr_o  = addr_q;
  assign pc_out_o     = pc_q;
  assign ir_out_o     = ir_q;
  assign ir_valid_o   = ir_valid_q;
  assign sr_out_o     = sr_q;
  assign epc_out_o    = epc_q;
  assign exc_taken_o  = taken_q;
  assign exc_cause_o  = cause_q;

endmodule
